// File: rtl/jpegls_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jpegls_pkg : shared encodings for the LOCO-I run-mode path            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package jpegls_pkg;

   localparam logic [1:0] MODE_NONE = 2'b00;
   localparam logic [1:0] MODE_EOL  = 2'b10;
   localparam logic [1:0] MODE_RI   = 2'b11;

   localparam int NEAR_DEFAULT = 0;
   localparam int CNT_W        = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_GAP  = 2'd2
   } run_state_e;

endpackage
`default_nettype wire

// File: rtl/run_mode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | run_mode_ctrl : run-mode sequencer issuing commands to the run coder  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module run_mode_ctrl
   import jpegls_pkg::*;
#(
   parameter int NEAR    = NEAR_DEFAULT,
   parameter int MAX_RUN = 1023,
   parameter int RI_GAP  = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pix_valid,
   output logic       pix_ready,
   input  logic       run_start,
   input  logic       eol,
   input  logic [8:0] Ix,
   input  logic [8:0] Ra,
   input  logic [8:0] Rb,
   output logic       in_run,
   output logic       en,
   output logic [1:0] mode,
   output logic [9:0] runcnt,
   output logic [8:0] Ra_o,
   output logic [8:0] Rb_o,
   output logic [8:0] Ix_o,
   output logic       run_ovf
);

   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_RUN);
   localparam logic [CNT_W-1:0] NEAR_W   = CNT_W'(NEAR);
   localparam logic [7:0]       GAP_LAST = (RI_GAP > 0) ? 8'(RI_GAP - 1) : 8'd0;

   run_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       gap_q, gap_d;
   logic             ovf_q, ovf_d;
   logic             en_q, en_d;
   logic [1:0]       mode_q, mode_d;
   logic [9:0]       runcnt_q, runcnt_d;
   logic [8:0]       ra_q, ra_d, rb_q, rb_d, ix_q, ix_d;

   logic signed [9:0] w_diff;
   logic [9:0]        w_absdiff;
   logic              w_match;
   logic              w_xfer;
   logic [CNT_W-1:0]  w_cnt_inc;
   run_state_e        w_after_ri;

   assign w_diff    = $signed({1'b0, Ix}) - $signed({1'b0, Ra});
   assign w_absdiff = w_diff[9] ? $unsigned(-w_diff) : $unsigned(w_diff);
   assign w_match   = (w_absdiff <= NEAR_W);

   assign pix_ready  = (state_q != ST_GAP);
   assign w_xfer     = pix_valid & pix_ready;
   assign w_cnt_inc  = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + 10'd1;
   // A zero-length gap returns straight to IDLE so intake is never throttled.
   assign w_after_ri = (RI_GAP == 0) ? ST_IDLE : ST_GAP;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      gap_d    = gap_q;
      ovf_d    = ovf_q;
      en_d     = 1'b0;
      mode_d   = MODE_NONE;
      runcnt_d = '0;
      ra_d     = '0;
      rb_d     = '0;
      ix_d     = '0;
      in_run   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_run = run_start;
            if (w_xfer && run_start) begin
               if (w_match && eol) begin
                  en_d     = 1'b1;
                  mode_d   = MODE_EOL;
                  runcnt_d = 10'd1;
               end else if (w_match) begin
                  cnt_d   = 10'd1;
                  state_d = ST_RUN;
               end else begin
                  en_d    = 1'b1;
                  mode_d  = MODE_RI;
                  ra_d    = Ra;
                  rb_d    = Rb;
                  ix_d    = Ix;
                  gap_d   = '0;
                  state_d = w_after_ri;
               end
            end
         end
         ST_RUN: begin
            in_run = 1'b1;
            if (w_xfer) begin
               if (w_match) begin
                  if (cnt_q == MAX_CNT) ovf_d = 1'b1;
                  if (eol) begin
                     en_d     = 1'b1;
                     mode_d   = MODE_EOL;
                     runcnt_d = w_cnt_inc;
                     cnt_d    = '0;
                     state_d  = ST_IDLE;
                  end else begin
                     cnt_d = w_cnt_inc;
                  end
               end else begin
                  en_d     = 1'b1;
                  mode_d   = MODE_RI;
                  runcnt_d = cnt_q;
                  ra_d     = Ra;
                  rb_d     = Rb;
                  ix_d     = Ix;
                  cnt_d    = '0;
                  gap_d    = '0;
                  state_d  = w_after_ri;
               end
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_LAST) begin
               gap_d   = '0;
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q + 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         gap_q    <= '0;
         ovf_q    <= 1'b0;
         en_q     <= 1'b0;
         mode_q   <= MODE_NONE;
         runcnt_q <= '0;
         ra_q     <= '0;
         rb_q     <= '0;
         ix_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         gap_q    <= gap_d;
         ovf_q    <= ovf_d;
         en_q     <= en_d;
         mode_q   <= mode_d;
         runcnt_q <= runcnt_d;
         ra_q     <= ra_d;
         rb_q     <= rb_d;
         ix_q     <= ix_d;
      end
   end

   assign en      = en_q;
   assign mode    = mode_q;
   assign runcnt  = runcnt_q;
   assign Ra_o    = ra_q;
   assign Rb_o    = rb_q;
   assign Ix_o    = ix_q;
   assign run_ovf = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_run_mode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_run_mode_ctrl : checks two configurations against a run model      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_run_mode_ctrl;

   localparam int RI_GAP   = 2;
   localparam int NEAR_K[2] = '{0, 2};
   localparam int MAXR_K[2] = '{1023, 4};

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       pix_valid, run_start, eol;
   logic [8:0] Ix, Ra, Rb;

   logic       a_ready, a_irun, a_en, a_ovf;
   logic [1:0] a_mode;
   logic [9:0] a_rc;
   logic [8:0] a_ra, a_rb, a_ix;
   logic       b_ready, b_irun, b_en, b_ovf;
   logic [1:0] b_mode;
   logic [9:0] b_rc;
   logic [8:0] b_ra, b_rb, b_ix;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   run_mode_ctrl #(.NEAR(0), .MAX_RUN(1023), .RI_GAP(RI_GAP)) u_a (
      .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_ready(a_ready),
      .run_start(run_start), .eol(eol), .Ix(Ix), .Ra(Ra), .Rb(Rb),
      .in_run(a_irun), .en(a_en), .mode(a_mode), .runcnt(a_rc),
      .Ra_o(a_ra), .Rb_o(a_rb), .Ix_o(a_ix), .run_ovf(a_ovf));

   run_mode_ctrl #(.NEAR(2), .MAX_RUN(4), .RI_GAP(RI_GAP)) u_b (
      .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_ready(b_ready),
      .run_start(run_start), .eol(eol), .Ix(Ix), .Ra(Ra), .Rb(Rb),
      .in_run(b_irun), .en(b_en), .mode(b_mode), .runcnt(b_rc),
      .Ra_o(b_ra), .Rb_o(b_rb), .Ix_o(b_ix), .run_ovf(b_ovf));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: run length so far, blocked cycles remaining, pending command.
   bit m_act[2];
   int m_len[2];
   int m_gap[2];
   bit m_ovf[2];
   bit e_en[2];
   int e_mode[2], e_rc[2], e_ra[2], e_rb[2], e_ix[2];

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < 2; k++) begin
            m_act[k] <= 1'b0; m_len[k] <= 0; m_gap[k] <= 0; m_ovf[k] <= 1'b0;
            e_en[k] <= 1'b0; e_mode[k] <= 0; e_rc[k] <= 0;
            e_ra[k] <= 0; e_rb[k] <= 0; e_ix[k] <= 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            automatic bit act = m_act[k];
            automatic int len = m_len[k];
            automatic int gap = m_gap[k];
            automatic bit ovf = m_ovf[k];
            automatic bit cen = 1'b0;
            automatic int cmode = 0, crc = 0, cra = 0, crb = 0, cix = 0;
            automatic int d = int'(Ix) - int'(Ra);
            automatic bit m = (d <= NEAR_K[k]) && (-d <= NEAR_K[k]);
            if (gap > 0) begin
               gap--;
            end else if (pix_valid && (act || run_start)) begin
               if (m) begin
                  if (act && len == MAXR_K[k]) ovf = 1'b1;
                  len = (len + 1 > MAXR_K[k]) ? MAXR_K[k] : len + 1;
                  if (eol) begin
                     cen = 1'b1; cmode = 2; crc = len; act = 1'b0; len = 0;
                  end else begin
                     act = 1'b1;
                  end
               end else begin
                  cen = 1'b1; cmode = 3; crc = len;
                  cra = int'(Ra); crb = int'(Rb); cix = int'(Ix);
                  act = 1'b0; len = 0; gap = RI_GAP;
               end
            end
            m_act[k] <= act; m_len[k] <= len; m_gap[k] <= gap; m_ovf[k] <= ovf;
            e_en[k] <= cen; e_mode[k] <= cmode; e_rc[k] <= crc;
            e_ra[k] <= cra; e_rb[k] <= crb; e_ix[k] <= cix;
         end
      end
   end

   task automatic cmp_inst(input int k, input string p, input logic rdy, input logic irun,
                           input logic en_, input logic [1:0] md, input logic [9:0] rc,
                           input logic [8:0] ra, input logic [8:0] rb, input logic [8:0] ix,
                           input logic ovf);
      chk({p, "_ready"},  32'(rdy),  32'(m_gap[k] == 0));
      chk({p, "_in_run"}, 32'(irun), 32'(m_act[k] || (m_gap[k] == 0 && run_start)));
      chk({p, "_en"},     32'(en_),  32'(e_en[k]));
      chk({p, "_mode"},   32'(md),   e_mode[k]);
      chk({p, "_runcnt"}, 32'(rc),   e_rc[k]);
      chk({p, "_Ra_o"},   32'(ra),   e_ra[k]);
      chk({p, "_Rb_o"},   32'(rb),   e_rb[k]);
      chk({p, "_Ix_o"},   32'(ix),   e_ix[k]);
      chk({p, "_ovf"},    32'(ovf),  32'(m_ovf[k]));
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         cmp_inst(0, "a", a_ready, a_irun, a_en, a_mode, a_rc, a_ra, a_rb, a_ix, a_ovf);
         cmp_inst(1, "b", b_ready, b_irun, b_en, b_ovf ? b_mode : b_mode, b_rc, b_ra, b_rb, b_ix, b_ovf);
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present a pixel and hold it until instance A accepts it.
   task automatic send(input logic rs, input logic e, input int ix, input int ra, input int rb);
      int n;
      pix_valid = 1'b1; run_start = rs; eol = e;
      Ix = 9'(ix); Ra = 9'(ra); Rb = 9'(rb);
      n = 0;
      while (!a_ready && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 20) begin
         n_cmp++; n_bad++;
         $display("FAIL send_timeout: got ready=0 expected ready=1 within 20 cycles");
      end
      @(posedge clk);
      #1;
      pix_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      pix_valid = 1'b0; run_start = 1'b0; eol = 1'b0; Ix = '0; Ra = '0; Rb = '0;
      #1 reset = 1'b0;
      #1 chk_on = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_en", 32'(a_en), 0);
      chk("rst_mode", 32'(a_mode), 0);
      chk("rst_runcnt", 32'(a_rc), 0);
      chk("rst_Ix_o", 32'(a_ix), 0);
      chk("rst_ovf", 32'(a_ovf), 0);
      reset = 1'b1;
      idle(1);
      chk("rst_ready", 32'(a_ready), 1);

      // Five equal pixels with a valid-low pause; last carries eol.
      send(1, 0, 37, 37, 5);
      send(1, 0, 37, 37, 5);
      idle(3);
      send(1, 0, 37, 37, 5);
      send(1, 0, 37, 37, 5);
      send(1, 1, 37, 37, 5);
      chk("eol_en", 32'(a_en), 1);
      chk("eol_mode", 32'(a_mode), 2);
      chk("eol_runcnt", 32'(a_rc), 5);
      chk("eol_ready", 32'(a_ready), 1);
      chk("sat_runcnt_b", 32'(b_rc), 4);
      chk("sat_ovf_b", 32'(b_ovf), 1);
      idle(1);
      chk("eol_en_drop", 32'(a_en), 0);
      chk("eol_mode_drop", 32'(a_mode), 0);

      // Three matches then an interruption sample.
      send(1, 0, 37, 37, 12);
      send(1, 0, 37, 37, 12);
      send(1, 0, 37, 37, 12);
      send(1, 0, 40, 37, 12);
      chk("ri_en", 32'(a_en), 1);
      chk("ri_mode", 32'(a_mode), 3);
      chk("ri_runcnt", 32'(a_rc), 3);
      chk("ri_Ix_o", 32'(a_ix), 40);
      chk("ri_Ra_o", 32'(a_ra), 37);
      chk("ri_Rb_o", 32'(a_rb), 12);
      chk("ri_gap1", 32'(a_ready), 0);
      idle(1);
      chk("ri_gap2", 32'(a_ready), 0);
      idle(1);
      chk("ri_gap_end", 32'(a_ready), 1);

      // Immediate interruption, then a pixel offered during the gap.
      send(1, 0, 50, 37, 9);
      chk("ri0_mode", 32'(a_mode), 3);
      chk("ri0_runcnt", 32'(a_rc), 0);
      pix_valid = 1'b1; run_start = 1'b1; eol = 1'b1; Ix = 9'd20; Ra = 9'd20;
      chk("gap_block", 32'(a_ready), 0);
      send(1, 1, 20, 20, 9);
      chk("after_gap_mode", 32'(a_mode), 2);
      chk("after_gap_runcnt", 32'(a_rc), 1);

      // Interruption sample carrying eol.
      repeat (4) send(1, 0, 60, 60, 3);
      send(1, 1, 100, 37, 3);
      chk("ri_eol_mode", 32'(a_mode), 3);
      chk("ri_eol_runcnt", 32'(a_rc), 4);
      run_start = 1'b0;
      idle(2);
      chk("ri_eol_ready", 32'(a_ready), 1);
      chk("ri_eol_idle", 32'(a_irun), 0);

      // Regular-path pixel with eol has no effect.
      send(0, 1, 5, 90, 3);
      chk("regular_no_en", 32'(a_en), 0);

      // Reset in the middle of a run of seven.
      repeat (7) send(1, 0, 11, 11, 1);
      reset = 1'b0;
      #1;
      chk("midrst_en", 32'(a_en), 0);
      chk("midrst_ovf", 32'(b_ovf), 0);
      chk("midrst_runcnt", 32'(a_rc), 0);
      idle(1);
      reset = 1'b1;
      send(1, 0, 11, 11, 1);
      send(1, 1, 11, 11, 1);
      chk("postrst_runcnt", 32'(a_rc), 2);

      // Saturation on B (MAX_RUN=4, NEAR=2); 39 vs 37 matches only on B.
      repeat (6) send(1, 0, 37, 37, 8);
      chk("ovf_set_b", 32'(b_ovf), 1);
      send(1, 1, 39, 37, 8);
      chk("ovf_b_en", 32'(b_en), 1);
      chk("ovf_b_mode", 32'(b_mode), 2);
      chk("ovf_b_runcnt", 32'(b_rc), 4);
      chk("near_a_mode", 32'(a_mode), 3);
      chk("near_a_runcnt", 32'(a_rc), 6);
      idle(3);
      chk("ovf_sticky_b", 32'(b_ovf), 1);

      idle(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/run_mode_ctrl.md
Name: run_mode_ctrl

Overview:
Sequencer for the run-mode path of the LOCO-I encoder. It accepts pixels flagged for run mode and counts matching samples (Ix within NEAR of Ra). It decides whether the run ends at end-of-line or by an interruption sample, then issues a single-cycle command (en, mode, runcnt, Ra/Rb/Ix) to run_coding_new. It also throttles intake after interruptions so the run_parameter context update (A/N/Nn) completes before the next interruption sample arrives.

Parameters:
NEAR, 0, match tolerance; a sample matches when |Ix-Ra| <= NEAR (0 = lossless)
MAX_RUN, 1023, runcnt saturation value; must be >= line width
RI_GAP, 2, idle cycles forced after a mode-3 issue (run-interruption context update latency)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
pix_valid  in  1  pixel presented this cycle
pix_ready  out  1  controller accepts pixel (transfer = pix_valid & pix_ready)
run_start  in  1  pixel's context gradients all zero (run-mode entry); sampled only in IDLE
eol  in  1  pixel is last of its line
Ix  in  9  current sample
Ra  in  9  left neighbour
Rb  in  9  upper neighbour
in_run  out  1  combinational: accepted pixel belongs to run path (top-level mux select)
en  out  1  one-cycle command strobe to run coder
mode  out  2  2'b00 none, 2'b10 run ended at EOL, 2'b11 run interrupted
runcnt  out  10  run length to encode
Ra_o  out  9  Ra of interruption sample (valid when mode=3)
Rb_o  out  9  Rb of interruption sample
Ix_o  out  9  interruption sample
run_ovf  out  1  sticky: a match arrived with cnt = MAX_RUN

Behaviour:
- Reset (async, reset=0): state=IDLE, cnt=0, gap=0; en=0, mode=0, runcnt=0, Ra_o/Rb_o/Ix_o=0, run_ovf=0. pix_ready=1 after release. Reset mid-run discards the partial run with no command issued.
- match = |Ix-Ra| <= NEAR, computed as a 10-bit signed difference.
- States: IDLE, RUN, GAP.
- IDLE: pix_ready=1. in_run = run_start. A transfer with run_start=0 is ignored: it belongs to the regular path, no state change.
- IDLE, transfer with run_start=1:
  - match & eol -> issue mode2, runcnt=1; stay IDLE.
  - match & !eol -> cnt=1; go RUN.
  - !match -> issue mode3, runcnt=0, latch Ra/Rb/Ix; go GAP.
- RUN: pix_ready=1, in_run=1. Each transfer:
  - match & eol -> issue mode2, runcnt=cnt+1 (saturating); go IDLE, cnt=0.
  - match & !eol -> cnt=cnt+1; if cnt=MAX_RUN, cnt holds and run_ovf sets.
  - !match (eol or not) -> issue mode3, runcnt=cnt, latch samples; cnt=0; go GAP.
- GAP: pix_ready=0, in_run=0; count RI_GAP cycles, then go IDLE. RI_GAP=0 skips GAP and goes straight to IDLE.
- Issue timing: outputs are registered. en=1 in the cycle after the terminating transfer, for exactly one cycle. mode/runcnt/samples are valid with en. When en=0 all command outputs return to 0.
- Mode-2 issues impose no gap, so back-to-back pixels stay accepted.
- pix_valid=0 holds all state, with no counting.
- eol on a non-run IDLE pixel has no effect.
- Widths: cnt is 10 bits, never wraps.

Decomposition:
- Shared package (jpegls_pkg): mode encodings MODE_NONE=2'b00, MODE_EOL=2'b10, MODE_RI=2'b11; state encodings; NEAR default.
- No sub-module is needed. The match comparator is inline (one subtract/abs).

Test Plan:
- Run of 5 equal pixels (Ix=Ra=37), 5th with eol -> one en pulse a cycle later, mode=2'b10, runcnt=5; pix_ready stays 1.
- Run of 3 matches then Ix=40, Ra=37, Rb=12 -> en, mode=2'b11, runcnt=3, Ix_o=40, Ra_o=37, Rb_o=12; pix_ready=0 for exactly 2 cycles, then 1.
- IDLE, run_start=1, Ix≠Ra -> mode=2'b11, runcnt=0. A further run_start pixel offered during GAP is not accepted until pix_ready rises.
- Interrupting sample also carries eol (4 matches, then mismatch + eol) -> mode=2'b11, runcnt=4; next state IDLE after GAP, not RUN.
- reset pulsed low while cnt=7 in RUN -> all outputs 0 immediately, no en ever issued for that run; the next run_start pixel begins cnt at 1.
- MAX_RUN=4, 6 matching pixels then eol match -> run_ovf=1 (sticky), runcnt=4. With NEAR=2, Ix=39, Ra=37 counts as a match.
